// File: rtl/ks_post_32b.sv
// Kogge-Stone post stage: sum/carry/overflow, optional saturation, and an overflow event counter.
// Latency is 1 cycle. A 2-entry skid buffer keeps o_ready a plain flop, so i_ready never reaches it combinationally.
module ks_post_32b #(
    parameter bit SAT_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_c0,
    input  logic [31:0] i_pk,
    input  logic [31:0] i_gk,
    input  logic        i_sat,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_sum,
    output logic        o_cout,
    output logic        o_ovf,
    input  logic        i_ovf_clr,
    output logic [15:0] o_ovf_cnt
);

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t        out_q, out_d;
    res_t        skid_q, skid_d;
    logic        out_v_q, out_v_d;
    logic        skid_v_q, skid_v_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    logic [31:0] carry_in;
    logic        raw_ovf;
    logic        accept;
    res_t        new_res;

    always_comb begin
        carry_in     = {i_gk[30:0], i_c0};
        raw_ovf      = i_gk[31] ^ i_gk[30];
        new_res.sum  = i_pk ^ carry_in;
        new_res.cout = i_gk[31];
        new_res.ovf  = raw_ovf;
        // Sign of the true result is pk[31]^cout; clamp toward it.
        if (SAT_EN && i_sat && raw_ovf) begin
            new_res.sum = (i_pk[31] ^ i_gk[31]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    assign accept = i_valid & ~skid_v_q;

    always_comb begin
        out_d    = out_q;
        skid_d   = skid_q;
        out_v_d  = out_v_q;
        skid_v_d = skid_v_q;
        case ({out_v_q, skid_v_q})
            2'b00: begin
                if (accept) begin
                    out_d   = new_res;
                    out_v_d = 1'b1;
                end
            end
            2'b10: begin
                if (accept && i_ready) begin
                    out_d = new_res;
                end else if (accept) begin
                    skid_d   = new_res;
                    skid_v_d = 1'b1;
                end else if (i_ready) begin
                    out_v_d = 1'b0;
                end
            end
            2'b11: begin
                if (i_ready) begin
                    out_d    = skid_q;
                    skid_v_d = 1'b0;
                end
            end
            default: begin
                out_v_d  = 1'b0;
                skid_v_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (i_ovf_clr) begin
            ovf_cnt_d = 16'd0;
        end else if (accept && raw_ovf && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q     <= '0;
            skid_q    <= '0;
            out_v_q   <= 1'b0;
            skid_v_q  <= 1'b0;
            ovf_cnt_q <= 16'd0;
        end else begin
            out_q     <= out_d;
            skid_q    <= skid_d;
            out_v_q   <= out_v_d;
            skid_v_q  <= skid_v_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign o_ready   = ~skid_v_q;
    assign o_valid   = out_v_q;
    assign o_sum     = out_q.sum;
    assign o_cout    = out_q.cout;
    assign o_ovf     = out_q.ovf;
    assign o_ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_ks_post_32b.sv
// Bench for ks_post_32b: directed cases plus a random stream against an arithmetic reference model.
module tb_ks_post_32b;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        exp_t r1;
        exp_t r0;
    } pair_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_c0 = 1'b0;
    logic [31:0] i_pk = '0;
    logic [31:0] i_gk = '0;
    logic        i_sat = 1'b0;
    logic        i_ready = 1'b0;
    logic        i_ovf_clr = 1'b0;

    logic        o_ready, o_valid, o_cout, o_ovf;
    logic [31:0] o_sum;
    logic [15:0] o_ovf_cnt;
    logic        o0_ready, o0_valid, o0_cout, o0_ovf;
    logic [31:0] o0_sum;
    logic [15:0] o0_ovf_cnt;

    int total = 0;
    int bad = 0;

    logic [31:0] cur_a, cur_b;
    logic        cur_c0, cur_sat;

    always #5 i_clk = ~i_clk;

    ks_post_32b #(.SAT_EN(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_c0(i_c0), .i_pk(i_pk), .i_gk(i_gk), .i_sat(i_sat),
        .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_cout(o_cout),
        .o_ovf(o_ovf), .i_ovf_clr(i_ovf_clr), .o_ovf_cnt(o_ovf_cnt)
    );

    ks_post_32b #(.SAT_EN(1'b0)) dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o0_ready),
        .i_c0(i_c0), .i_pk(i_pk), .i_gk(i_gk), .i_sat(i_sat),
        .o_valid(o0_valid), .i_ready(i_ready), .o_sum(o0_sum), .o_cout(o0_cout),
        .o_ovf(o0_ovf), .i_ovf_clr(i_ovf_clr), .o_ovf_cnt(o0_ovf_cnt)
    );

    // Carry out of bit k, found by adding the low k+1 bits of the operands.
    function automatic logic [31:0] gen_gk(input logic [31:0] a, input logic [31:0] b, input logic c0);
        logic [31:0] g;
        logic [63:0] m, t;
        g = '0;
        for (int k = 0; k < 32; k++) begin
            m    = (64'd1 << (k + 1)) - 64'd1;
            t    = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, c0};
            g[k] = t[k + 1];
        end
        return g;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c0,
                                   input logic sat, input bit sat_en);
        exp_t        r;
        logic [32:0] full;
        full   = {1'b0, a} + {1'b0, b} + {32'd0, c0};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
        if (sat_en && sat && r.ovf) r.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return r;
    endfunction

    task automatic drive_beat(input logic [31:0] a, input logic [31:0] b, input logic c0, input logic sat);
        cur_a   = a;
        cur_b   = b;
        cur_c0  = c0;
        cur_sat = sat;
        i_pk    = a ^ b;
        i_gk    = gen_gk(a, b, c0);
        i_c0    = c0;
        i_sat   = sat;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
        total++; if ({o_sum, o_cout, o_ovf} !== 34'd0) begin bad++; $display("FAIL reset_data got=%h/%b/%b want=0", o_sum, o_cout, o_ovf); end
        total++; if (o_ovf_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%h want=0", o_ovf_cnt); end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        i_ready = 1'b1;
        i_valid = 1'b1;
        drive_beat(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        tick();
        drive_beat(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        @(negedge i_clk);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL wrap1_valid got=%b want=1", o_valid); end
        total++; if (o_sum !== 32'h8000_0000) begin bad++; $display("FAIL wrap1_sum got=%h want=80000000", o_sum); end
        total++; if ({o_cout, o_ovf} !== 2'b01) begin bad++; $display("FAIL wrap1_flags got=%b%b want=01", o_cout, o_ovf); end
        total++; if (o_ovf_cnt !== 16'd1) begin bad++; $display("FAIL wrap1_cnt got=%h want=1", o_ovf_cnt); end
        tick();
        i_valid = 1'b0;
        @(negedge i_clk);
        total++; if (o_sum !== 32'h0) begin bad++; $display("FAIL wrap2_sum got=%h want=0", o_sum); end
        total++; if ({o_cout, o_ovf} !== 2'b10) begin bad++; $display("FAIL wrap2_flags got=%b%b want=10", o_cout, o_ovf); end
        total++; if (o_ovf_cnt !== 16'd1) begin bad++; $display("FAIL wrap2_cnt got=%h want=1", o_ovf_cnt); end
        tick();
    endtask

    task automatic test_saturation();
        i_ready = 1'b1;
        i_valid = 1'b1;
        drive_beat(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        tick();
        drive_beat(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        @(negedge i_clk);
        total++; if (o_sum !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_pos_sum got=%h want=7fffffff", o_sum); end
        total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL sat_pos_ovf got=%b want=1", o_ovf); end
        total++; if (o0_sum !== 32'h8000_0000) begin bad++; $display("FAIL nosat_pos_sum got=%h want=80000000", o0_sum); end
        tick();
        i_valid = 1'b0;
        @(negedge i_clk);
        total++; if (o_sum !== 32'h8000_0000) begin bad++; $display("FAIL sat_neg_sum got=%h want=80000000", o_sum); end
        total++; if ({o_cout, o_ovf} !== 2'b11) begin bad++; $display("FAIL sat_neg_flags got=%b%b want=11", o_cout, o_ovf); end
        total++; if (o0_sum !== 32'h7FFF_FFFF) begin bad++; $display("FAIL nosat_neg_sum got=%h want=7fffffff", o0_sum); end
        tick();
    endtask

    task automatic test_backpressure();
        int sent = 1;
        int next = 1;
        i_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            i_ready = (c >= 4);
            i_valid = (sent <= 4);
            drive_beat(sent, 32'd0, 1'b0, 1'b0);
            @(negedge i_clk);
            if (c == 2 || c == 3) begin
                total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low c=%0d got=%b want=0", c, o_ready); end
                total++; if (o_valid !== 1'b1 || o_sum !== 32'd1) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%h want=1/1", c, o_valid, o_sum); end
            end
            if (o_valid && i_ready) begin
                total++; if (o_sum !== next) begin bad++; $display("FAIL bp_order got=%0d want=%0d", o_sum, next); end
                next++;
            end
            if (i_valid && o_ready) sent++;
            tick();
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        total++; if (next !== 5) begin bad++; $display("FAIL bp_count got=%0d want=5", next - 1); end
        total++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin bad++; $display("FAIL bp_final got=%b/%b want=1/0", o_ready, o_valid); end
        tick();
    endtask

    task automatic test_random();
        pair_t       q[$];
        pair_t       e;
        logic [15:0] cnt_m;
        logic        acc, ovf_now;
        i_valid   = 1'b0;
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        cnt_m = 16'd0;
        for (int c = 0; c < 720; c++) begin
            if (c < 700) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i_ready = ($urandom_range(0, 2) != 0);
                i_ovf_clr = ($urandom_range(0, 49) == 0);
                drive_beat($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                i_valid = 1'b0;
                i_ready = 1'b1;
                i_ovf_clr = 1'b0;
            end
            @(negedge i_clk);
            total++; if (o_ovf_cnt !== cnt_m) begin bad++; $display("FAIL rnd_cnt c=%0d got=%h want=%h", c, o_ovf_cnt, cnt_m); end
            if (o_valid) begin
                if (q.size() == 0) begin
                    total++; bad++; $display("FAIL rnd_spurious c=%0d got=%h want=none", c, o_sum);
                end else begin
                    e = q[0];
                    total++; if ({o_sum, o_cout, o_ovf} !== e.r1) begin bad++; $display("FAIL rnd_out c=%0d got=%h/%b/%b want=%h/%b/%b", c, o_sum, o_cout, o_ovf, e.r1.sum, e.r1.cout, e.r1.ovf); end
                    total++; if (o0_sum !== e.r0.sum) begin bad++; $display("FAIL rnd_nosat c=%0d got=%h want=%h", c, o0_sum, e.r0.sum); end
                    if (i_ready) void'(q.pop_front());
                end
            end
            acc = i_valid && o_ready;
            ovf_now = model(cur_a, cur_b, cur_c0, cur_sat, 1'b0).ovf;
            if (acc) begin
                e.r1 = model(cur_a, cur_b, cur_c0, cur_sat, 1'b1);
                e.r0 = model(cur_a, cur_b, cur_c0, cur_sat, 1'b0);
                q.push_back(e);
            end
            if (i_ovf_clr) cnt_m = 16'd0;
            else if (acc && ovf_now && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            tick();
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_drain left=%0d want=0", q.size()); end
    endtask

    task automatic test_counter();
        i_ready   = 1'b1;
        i_valid   = 1'b0;
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        @(negedge i_clk);
        total++; if (o_ovf_cnt !== 16'd0) begin bad++; $display("FAIL cnt_clear got=%h want=0", o_ovf_cnt); end
        drive_beat(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        tick();
        i_valid = 1'b1;
        repeat (65534) tick();
        @(negedge i_clk);
        total++; if (o_ovf_cnt !== 16'hFFFE) begin bad++; $display("FAIL cnt_fffe got=%h want=fffe", o_ovf_cnt); end
        tick();
        i_valid = 1'b0;
        @(negedge i_clk);
        total++; if (o_ovf_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_ffff got=%h want=ffff", o_ovf_cnt); end
        tick();
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        @(negedge i_clk);
        total++; if (o_ovf_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_hold got=%h want=ffff", o_ovf_cnt); end
        tick();
        i_valid   = 1'b1;
        i_ovf_clr = 1'b1;
        tick();
        i_valid   = 1'b0;
        i_ovf_clr = 1'b0;
        @(negedge i_clk);
        total++; if (o_ovf_cnt !== 16'd0) begin bad++; $display("FAIL cnt_clr_prio got=%h want=0", o_ovf_cnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        i_valid = 1'b1;
        drive_beat(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        tick();
        drive_beat(32'd5, 32'd6, 1'b0, 1'b0);
        tick();
        i_valid = 1'b0;
        @(negedge i_clk);
        total++; if (o_ready !== 1'b0 || o_ovf_cnt !== 16'd1) begin bad++; $display("FAIL rm_full got=%b/%h want=0/1", o_ready, o_ovf_cnt); end
        #2;
        i_rst_n = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin bad++; $display("FAIL rm_hs got=%b/%b want=0/1", o_valid, o_ready); end
        total++; if ({o_sum, o_cout, o_ovf, o_ovf_cnt} !== 50'd0) begin bad++; $display("FAIL rm_data got=%h/%b/%b/%h want=0", o_sum, o_cout, o_ovf, o_ovf_cnt); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        i_valid = 1'b1;
        drive_beat(32'd100, 32'd23, 1'b1, 1'b0);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        total++; if (o_valid !== 1'b1 || o_sum !== 32'd124) begin bad++; $display("FAIL rm_after got=%b/%0d want=1/124", o_valid, o_sum); end
        tick();
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturation();
        test_backpressure();
        test_random();
        test_counter();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ks_post_32b.md
# ks_post_32b

Final post-processing stage of the 32-bit Kogge-Stone adder, the consumer of the last prefix stage's outputs (`c0`, saved propagate vector, group-generate vector). It forms the 32-bit sum, carry-out and signed overflow, optionally saturates the result, and presents it through a registered valid/ready output with a 2-entry skid buffer. The FFT datapath can therefore apply backpressure without combinational ready paths back into the prefix tree. It also keeps a saturating count of overflow events for butterfly scaling diagnostics.

## Interface
- `SAT_EN`, 1: 1 = saturation logic present and controlled by `i_sat`; 0 = `i_sat` ignored, result always wraps.
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_valid`  in  1  upstream beat valid.
- `o_ready`  out  1  stage can accept a beat this cycle.
- `i_c0`  in  1  carry-in of the addition.
- `i_pk`  in  32  saved per-bit propagate, `a[k]^b[k]`.
- `i_gk`  in  32  group generate: `i_gk[k]` = carry out of bit k, including carry-in.
- `i_sat`  in  1  per-beat saturation request.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  downstream accepts the result.
- `o_sum`  out  32  sum.
- `o_cout`  out  1  unsigned carry-out.
- `o_ovf`  out  1  signed overflow of this beat, raw and before saturation.
- `i_ovf_clr`  in  1  synchronous clear of the overflow counter.
- `o_ovf_cnt`  out  16  overflow event count, saturating.

## Operation
- Carry into bit 0 = `i_c0`; carry into bit k (k≥1) = `i_gk[k-1]`.
- `sum[k] = i_pk[k] ^ carry_in[k]`.
- `cout = i_gk[31]`.
- `ovf = i_gk[31] ^ i_gk[30]`.
- Saturation applies when `SAT_EN=1`, `i_sat=1` and `ovf=1`:
  - `o_sum` = 0x7FFFFFFF if `i_pk[31]^i_gk[31]` is 0, i.e. operands positive.
  - `o_sum` = 0x80000000 otherwise.
  - `o_cout` and `o_ovf` keep their raw values.
- The handshake accepts a beat when `i_valid & o_ready`.
- Storage is one output register (OUT) plus one skid register (SKID), with valid bits `out_v` and `skid_v`.
- States, from {out_v, skid_v}:
  - EMPTY (0,0): an accepted beat loads OUT.
  - ONE (1,0):
    - accept with `i_ready`: OUT reloads.
    - accept without `i_ready`: the beat goes to SKID, giving FULL.
    - `i_ready` with no accept: back to EMPTY.
  - FULL (1,1): no accept is possible. On `i_ready`, OUT takes SKID and the state returns to ONE.
- `o_ready = ~skid_v`, taken directly from a flop.
- `o_valid = out_v`.
- `o_sum`, `o_cout` and `o_ovf` come from OUT.
- Data is computed at acceptance and stored in post-saturation form.
- Overflow counter:
  - Increments on each accepted beat with raw `ovf=1`.
  - Holds at 0xFFFF.
  - `i_ovf_clr` has priority over a same-cycle event: the result is 0.
- Ordering is strict FIFO. No beat is dropped or duplicated.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `o_sum` after edge N. With no backpressure, throughput is 1 beat per cycle.
- `o_ready` falls the cycle after the skid register fills and rises the cycle after it drains.
- While `o_valid=1` and `i_ready=0`, outputs hold stable.
- Reset, asynchronous and entered at any time including mid-transfer, gives:
  - `out_v=0`, `skid_v=0`, so `o_valid=0` and `o_ready=1`.
  - `o_sum=0`, `o_cout=0`, `o_ovf=0`, `o_ovf_cnt=0`.
  - In-flight beats are discarded.
- On release, the first accept is possible at the first rising edge with `i_rst_n=1`.
- No combinational path from `i_ready` to `o_ready` or from `i_valid` to `o_valid`.

## Test plan
- Wrap addition:
  - 0x7FFFFFFF+1 (c0=0) with `i_sat=0` -> `o_sum`=0x80000000, `o_cout`=0, `o_ovf`=1, `o_ovf_cnt`=1, one cycle after accept.
  - 0xFFFFFFFF+1 -> `o_sum`=0, `o_cout`=1, `o_ovf`=0.
- Saturation:
  - Same 0x7FFFFFFF+1 with `i_sat=1` -> `o_sum`=0x7FFFFFFF, `o_ovf`=1.
  - 0x80000000+0xFFFFFFFF -> `o_sum`=0x80000000.
  - With `SAT_EN=0` -> wrapped value.
- Backpressure:
  - Stream beats 1,2,3,4 with `i_ready=0` from cycle 1 -> OUT=1, SKID=2, `o_ready`=0 at the next edge.
  - Raise `i_ready` -> outputs 1,2,3,4 in order, none lost, `o_ready` returns to 1.
- Random full-throughput stream (carry-in random) with `i_ready` toggling randomly -> every `o_sum` equals a+b+c0 mod 2^32 against a scoreboard, in order.
- Counter:
  - Force 0xFFFF overflow beats, then one more -> count stays 0xFFFF.
  - `i_ovf_clr` in the same cycle as an overflow beat -> count reads 0.
- Reset mid-operation: assert `i_rst_n=0` while FULL -> immediately `o_valid`=0, `o_ready`=1, outputs 0. After release, a new beat passes with 1-cycle latency.
